// File: rtl/llc_lookup_ctrl.sv
// Last-level cache lookup controller: set-associative tag/MESI store with tree-PLRU
// replacement, sequenced IDLE -> LOOKUP -> UPDATE -> RESP with a valid/ready response.
module llc_lookup_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned OFFSET_BITS   = 6,
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned ASSOCIATIVITY = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             req_valid,
    output logic                                             req_ready,
    input  logic [1:0]                                       req_op,
    input  logic [ADDR_WIDTH-1:0]                            req_addr,
    output logic                                             resp_valid,
    input  logic                                             resp_ready,
    output logic                                             resp_hit,
    output logic [$clog2(ASSOCIATIVITY)-1:0]                 resp_way,
    output logic [1:0]                                       resp_mesi,
    output logic                                             resp_wb,
    output logic [ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-1:0]     resp_wb_tag
);

    localparam int unsigned TAG_W  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned WAY_W  = $clog2(ASSOCIATIVITY);
    localparam int unsigned SETS   = 2 ** INDEX_BITS;
    localparam int unsigned PLRU_W = ASSOCIATIVITY - 1;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_M = 2'b10;
    localparam logic [1:0] MESI_E = 2'b11;

    localparam logic [1:0] OP_READ     = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_SNOOP_RD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_UPDATE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ASSOCIATIVITY-1:0][1:0]       mesi_mem [SETS];
    logic [ASSOCIATIVITY-1:0][TAG_W-1:0] tag_mem  [SETS];
    logic [PLRU_W-1:0]                   plru_mem [SETS];

    logic [1:0]            op_q;
    logic [INDEX_BITS-1:0] set_q;
    logic [TAG_W-1:0]      req_tag_q;

    logic                  lk_hit_c;
    logic [WAY_W-1:0]      lk_way_c;
    logic                  lk_hit_q;
    logic [WAY_W-1:0]      lk_way_q;
    logic [1:0]            lk_mesi_q;
    logic [TAG_W-1:0]      lk_tag_q;

    logic                  mem_we;
    logic                  plru_we;
    logic [1:0]            new_mesi;
    logic [PLRU_W-1:0]     new_plru;

    logic                  req_ready_d, resp_valid_d, resp_hit_d, resp_wb_d;
    logic [WAY_W-1:0]      resp_way_d;
    logic [1:0]            resp_mesi_d;
    logic [TAG_W-1:0]      resp_wb_tag_d;

    // Offset bits only pick a byte inside the line; they never take part in the lookup.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

    // Walk the tree following the stored direction bits down to the victim leaf.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] v);
        int unsigned       node;
        logic [PLRU_W-1:0] sh;
        node = 0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            sh   = v >> node;
            node = 2 * node + 1 + 32'(sh[0]);
        end
        return WAY_W'(node - PLRU_W);
    endfunction

    // Point every node on the accessed way's path at the opposite subtree.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] v,
                                                     input logic [WAY_W-1:0]  way);
        int unsigned       node;
        logic [WAY_W-1:0]  wsh;
        logic [PLRU_W-1:0] mask;
        logic [PLRU_W-1:0] r;
        node = 0;
        r    = v;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            wsh  = way >> (WAY_W - 1 - l);
            mask = PLRU_W'(1) << node;
            r    = wsh[0] ? (r & ~mask) : (r | mask);
            node = 2 * node + 1 + 32'(wsh[0]);
        end
        return r;
    endfunction

    // Tag compare across the set plus victim selection for a possible allocation.
    always_comb begin
        logic             inv_found;
        logic [WAY_W-1:0] inv_way;
        logic [WAY_W-1:0] hit_way;
        lk_hit_c  = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
            if (!lk_hit_c && mesi_mem[set_q][WAY_W'(w)] != MESI_I &&
                tag_mem[set_q][WAY_W'(w)] == req_tag_q) begin
                lk_hit_c = 1'b1;
                hit_way  = WAY_W'(w);
            end
            if (!inv_found && mesi_mem[set_q][WAY_W'(w)] == MESI_I) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        if (lk_hit_c)       lk_way_c = hit_way;
        else if (inv_found) lk_way_c = inv_way;
        else                lk_way_c = plru_victim(plru_mem[set_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid && req_ready)   state_d = S_LOOKUP;
            S_LOOKUP:                               state_d = S_UPDATE;
            S_UPDATE:                               state_d = S_RESP;
            S_RESP:   if (resp_valid && resp_ready) state_d = S_IDLE;
            default:                                state_d = S_IDLE;
        endcase
    end

    // Line-state update and next response values; responses hold while stalled.
    always_comb begin
        mem_we        = 1'b0;
        plru_we       = 1'b0;
        new_mesi      = lk_mesi_q;
        new_plru      = plru_touch(plru_mem[set_q], lk_way_q);
        req_ready_d   = (state_d == S_IDLE);
        resp_valid_d  = (state_d == S_RESP);
        resp_hit_d    = 1'b0;
        resp_way_d    = '0;
        resp_mesi_d   = MESI_I;
        resp_wb_d     = 1'b0;
        resp_wb_tag_d = '0;
        case (state_q)
            S_UPDATE: begin
                if (op_q == OP_READ || op_q == OP_WRITE) begin
                    mem_we  = 1'b1;
                    plru_we = 1'b1;
                    if (op_q == OP_WRITE) new_mesi = MESI_M;
                    else if (!lk_hit_q)   new_mesi = MESI_E;
                    resp_hit_d  = lk_hit_q;
                    resp_way_d  = lk_way_q;
                    resp_mesi_d = new_mesi;
                    if (!lk_hit_q && lk_mesi_q == MESI_M) begin
                        resp_wb_d     = 1'b1;
                        resp_wb_tag_d = lk_tag_q;
                    end
                end else if (lk_hit_q) begin
                    mem_we      = 1'b1;
                    new_mesi    = (op_q == OP_SNOOP_RD) ? MESI_S : MESI_I;
                    resp_hit_d  = 1'b1;
                    resp_way_d  = lk_way_q;
                    resp_mesi_d = new_mesi;
                    if (lk_mesi_q == MESI_M) begin
                        resp_wb_d     = 1'b1;
                        resp_wb_tag_d = lk_tag_q;
                    end
                end
            end
            S_RESP: begin
                if (!resp_ready) begin
                    resp_hit_d    = resp_hit;
                    resp_way_d    = resp_way;
                    resp_mesi_d   = resp_mesi;
                    resp_wb_d     = resp_wb;
                    resp_wb_tag_d = resp_wb_tag;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_mesi   <= MESI_I;
            resp_wb     <= 1'b0;
            resp_wb_tag <= '0;
        end else begin
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_hit    <= resp_hit_d;
            resp_way    <= resp_way_d;
            resp_mesi   <= resp_mesi_d;
            resp_wb     <= resp_wb_d;
            resp_wb_tag <= resp_wb_tag_d;
        end
    end

    // Request capture and lookup result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_READ;
            set_q     <= '0;
            req_tag_q <= '0;
            lk_hit_q  <= 1'b0;
            lk_way_q  <= '0;
            lk_mesi_q <= MESI_I;
            lk_tag_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid && req_ready) begin
                op_q      <= req_op;
                set_q     <= req_addr[OFFSET_BITS +: INDEX_BITS];
                req_tag_q <= req_addr[ADDR_WIDTH-1 -: TAG_W];
            end
            if (state_q == S_LOOKUP) begin
                lk_hit_q  <= lk_hit_c;
                lk_way_q  <= lk_way_c;
                lk_mesi_q <= mesi_mem[set_q][lk_way_c];
                lk_tag_q  <= tag_mem[set_q][lk_way_c];
            end
        end
    end

    // Per-set line state and replacement tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                mesi_mem[INDEX_BITS'(s)] <= '0;
                tag_mem[INDEX_BITS'(s)]  <= '0;
                plru_mem[INDEX_BITS'(s)] <= '0;
            end
        end else begin
            if (mem_we) begin
                mesi_mem[set_q][lk_way_q] <= new_mesi;
                tag_mem[set_q][lk_way_q]  <= req_tag_q;
            end
            if (plru_we) plru_mem[set_q] <= new_plru;
        end
    end

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// Scoreboard bench for llc_lookup_ctrl: expected responses queued at issue,
// compared when the response appears, plus stall and reset scenarios.
module tb_llc_lookup_ctrl;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_SRD = 2'd2;
    localparam logic [1:0] OP_SIN = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [1:0]  resp_mesi;
    logic        resp_wb;
    logic [19:0] resp_wb_tag;

    typedef struct {
        logic        hit;
        logic [1:0]  way;
        logic [1:0]  mesi;
        logic        wb;
        logic [19:0] wb_tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    llc_lookup_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way),
        .resp_mesi   (resp_mesi),
        .resp_wb     (resp_wb),
        .resp_wb_tag (resp_wb_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_resp(input string pfx, input exp_t e);
        chk({pfx, "_hit"},    32'(resp_hit),    32'(e.hit));
        chk({pfx, "_way"},    32'(resp_way),    32'(e.way));
        chk({pfx, "_mesi"},   32'(resp_mesi),   32'(e.mesi));
        chk({pfx, "_wb"},     32'(resp_wb),     32'(e.wb));
        chk({pfx, "_wb_tag"}, 32'(resp_wb_tag), 32'(e.wb_tag));
    endtask

    // Called and returns at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit",   32'(resp_hit),   32'd0);
        chk("rst_resp_way",   32'(resp_way),   32'd0);
        chk("rst_resp_mesi",  32'(resp_mesi),  32'd0);
        chk("rst_resp_wb",    32'(resp_wb),    32'd0);
        chk("rst_wb_tag",     32'(resp_wb_tag), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
    endtask

    // Issue one request; stall > 0 keeps resp_ready low and req_valid high for that many cycles.
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic e_hit,
                        input logic [1:0] e_way, input logic [1:0] e_mesi, input logic e_wb,
                        input logic [19:0] e_tag, input int stall);
        exp_t e;
        int   cyc;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_accept", 32'(req_ready), 32'd1);
        e.hit = e_hit; e.way = e_way; e.mesi = e_mesi; e.wb = e_wb; e.wb_tag = e_tag;
        sb.push_back(e);
        resp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        if (stall == 0) req_valid = 1'b0;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("resp_latency", 32'(cyc), 32'd3);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        e = sb.pop_front();
        cmp_resp($sformatf("op%0d_%0h", op, addr), e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            cmp_resp("stall", e);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Allocate then hit.
        send(OP_RD, 32'h1040, 0, 2'd0, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h1040, 1, 2'd0, 2'b11, 0, 20'h0, 0);

        // Fill a set, evict a dirty line, then follow the PLRU tree.
        do_reset();
        send(OP_WR, 32'h1040, 0, 2'd0, 2'b10, 0, 20'h0, 0);
        send(OP_RD, 32'h2040, 0, 2'd1, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h3040, 0, 2'd2, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h4040, 0, 2'd3, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h5040, 0, 2'd0, 2'b11, 1, 20'h1, 0);
        send(OP_RD, 32'h6040, 0, 2'd2, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h2040, 1, 2'd1, 2'b11, 0, 20'h0, 0);
        send(OP_RD, 32'h7040, 0, 2'd3, 2'b11, 0, 20'h0, 0);
        send(OP_WR, 32'h2040, 1, 2'd1, 2'b10, 0, 20'h0, 0);
        send(OP_SRD, 32'h2040, 1, 2'd1, 2'b01, 1, 20'h2, 0);
        send(OP_SRD, 32'h2040, 1, 2'd1, 2'b01, 0, 20'h0, 0);
        send(OP_RD, 32'h1080, 0, 2'd0, 2'b11, 0, 20'h0, 0);

        // Snoop downgrade and invalidate.
        do_reset();
        send(OP_WR,  32'h1040, 0, 2'd0, 2'b10, 0, 20'h0, 0);
        send(OP_SRD, 32'h1040, 1, 2'd0, 2'b01, 1, 20'h1, 0);
        send(OP_SIN, 32'h1040, 1, 2'd0, 2'b00, 0, 20'h0, 0);
        send(OP_RD,  32'h1040, 0, 2'd0, 2'b11, 0, 20'h0, 0);

        // Response backpressure with a request waiting behind it.
        send(OP_RD, 32'h1040, 1, 2'd0, 2'b11, 0, 20'h0, 5);
        send(OP_RD, 32'h1040, 1, 2'd0, 2'b11, 0, 20'h0, 0);

        // Reset while a WRITE sits in UPDATE: dropped, nothing written.
        do_reset();
        req_valid = 1'b1;
        req_op    = OP_WR;
        req_addr  = 32'h1040;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        send(OP_RD, 32'h1040, 0, 2'd0, 2'b11, 0, 20'h0, 0);

        // Snoop miss leaves the set untouched.
        do_reset();
        send(OP_SIN, 32'h7040, 0, 2'd0, 2'b00, 0, 20'h0, 0);
        send(OP_RD,  32'h7040, 0, 2'd0, 2'b11, 0, 20'h0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
